// File: rtl/redc_partition_scheduler_if.sv
// Column-memory read port and redundancy-controller handshake driven by the
// partition scheduler (master) and served by memory/controller (slave).
interface redc_partition_scheduler_if #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned RSIZ_WIDTH = 2,
    parameter int unsigned STEP_RANGE = 128,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                             mem_rd_en;
    logic [ADDR_WIDTH-1:0]            mem_rd_addr;
    logic [WORD_WIDTH*STEP_RANGE-1:0] mem_rd_data;
    logic                             rc_enable;
    logic [RSIZ_WIDTH-1:0]            rc_rsiz;
    logic [WORD_WIDTH-1:0]            rc_kidx;
    logic [WORD_WIDTH*STEP_RANGE-1:0] rc_lifm_column;
    logic                             rc_valid;

    modport master (
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output rc_enable, rc_rsiz, rc_kidx, rc_lifm_column,
        input  rc_valid
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  rc_enable, rc_rsiz, rc_kidx, rc_lifm_column,
        output rc_valid
    );
endinterface

// File: rtl/redc_partition_scheduler.sv
// Walks the lowered input feature map window by window, issuing row partitions
// of up to rsiz kernel elements to the redundancy controller one at a time.
module redc_partition_scheduler #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned RSIZ_WIDTH = 2,
    parameter int unsigned STEP_RANGE = 128,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [WORD_WIDTH-1:0]     n_kidx,
    input  logic [WORD_WIDTH-1:0]     n_steps,
    input  logic [RSIZ_WIDTH-1:0]     rsiz,
    redc_partition_scheduler_if.master bus,
    output logic [WORD_WIDTH-1:0]     part_step,
    output logic [WORD_WIDTH-1:0]     part_kidx0,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);

    localparam int unsigned COL_WIDTH = WORD_WIDTH * STEP_RANGE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] nk_q, nk_d;
    logic [WORD_WIDTH-1:0] ns_q, ns_d;
    logic [RSIZ_WIDTH-1:0] rs_q, rs_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] step_q, step_d;
    logic [WORD_WIDTH-1:0] kidx0_q, kidx0_d;
    logic [RSIZ_WIDTH-1:0] row_q, row_d;
    logic [RSIZ_WIDTH-1:0] psz_q, psz_d;
    logic                  rc_enable_q, rc_enable_d;
    logic [WORD_WIDTH-1:0] rc_kidx_q, rc_kidx_d;
    logic                  cfg_err_q, cfg_err_d;

    logic                  issuing;
    logic [WORD_WIDTH-1:0] next_kidx0;
    logic [WORD_WIDTH-1:0] next_step;
    logic [COL_WIDTH-1:0]  column;

    // Partition never spans a window: clip to the kernel elements left.
    function automatic logic [RSIZ_WIDTH-1:0] part_size(
        input logic [RSIZ_WIDTH-1:0] rs,
        input logic [WORD_WIDTH-1:0] nk,
        input logic [WORD_WIDTH-1:0] k0
    );
        logic [WORD_WIDTH-1:0] remain;
        remain = nk - k0;
        if (remain < WORD_WIDTH'(rs)) part_size = remain[RSIZ_WIDTH-1:0];
        else                          part_size = rs;
    endfunction

    always_comb begin
        state_d     = state_q;
        nk_d        = nk_q;
        ns_d        = ns_q;
        rs_d        = rs_q;
        addr_d      = addr_q;
        step_d      = step_q;
        kidx0_d     = kidx0_q;
        row_d       = row_q;
        psz_d       = psz_q;
        rc_enable_d = 1'b0;
        rc_kidx_d   = rc_kidx_q;
        cfg_err_d   = 1'b0;
        issuing     = 1'b0;
        next_kidx0  = kidx0_q + WORD_WIDTH'(psz_q);
        next_step   = step_q + WORD_WIDTH'(1);

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    nk_d = n_kidx;
                    ns_d = n_steps;
                    rs_d = rsiz;
                    if (rsiz < RSIZ_WIDTH'(2) || n_kidx == '0 || n_steps == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        addr_d  = '0;
                        step_d  = '0;
                        kidx0_d = '0;
                        row_d   = '0;
                        psz_d   = part_size(rsiz, n_kidx, '0);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                issuing     = 1'b1;
                rc_enable_d = 1'b1;
                rc_kidx_d   = kidx0_q + WORD_WIDTH'(row_q);
                addr_d      = addr_q + ADDR_WIDTH'(1);
                if (row_q == psz_q - RSIZ_WIDTH'(1)) begin
                    row_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    row_d = row_q + RSIZ_WIDTH'(1);
                end
            end
            S_WAIT: begin
                // The last column is still in flight while rc_enable is high.
                if (bus.rc_valid && !rc_enable_q) begin
                    if (next_kidx0 == nk_q) begin
                        kidx0_d = '0;
                        step_d  = next_step;
                        if (next_step == ns_q) begin
                            state_d = S_DONE;
                        end else begin
                            psz_d   = part_size(rs_q, nk_q, '0);
                            state_d = S_ISSUE;
                        end
                    end else begin
                        kidx0_d = next_kidx0;
                        psz_d   = part_size(rs_q, nk_q, next_kidx0);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            rc_enable_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            nk_q        <= '0;
            ns_q        <= '0;
            rs_q        <= '0;
            addr_q      <= '0;
            step_q      <= '0;
            kidx0_q     <= '0;
            row_q       <= '0;
            psz_q       <= '0;
            rc_enable_q <= 1'b0;
            rc_kidx_q   <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            nk_q        <= nk_d;
            ns_q        <= ns_d;
            rs_q        <= rs_d;
            addr_q      <= addr_d;
            step_q      <= step_d;
            kidx0_q     <= kidx0_d;
            row_q       <= row_d;
            psz_q       <= psz_d;
            rc_enable_q <= rc_enable_d;
            rc_kidx_q   <= rc_kidx_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign column             = bus.mem_rd_data;
    assign bus.rc_lifm_column = column;
    assign bus.mem_rd_en      = issuing;
    assign bus.mem_rd_addr    = addr_q;
    assign bus.rc_enable      = rc_enable_q;
    assign bus.rc_rsiz        = psz_q;
    assign bus.rc_kidx        = rc_kidx_q;
    assign part_step          = step_q;
    assign part_kidx0         = kidx0_q;
    assign busy               = (state_q != S_IDLE);
    assign done               = (state_q == S_DONE);
    assign cfg_err            = cfg_err_q;

endmodule

// File: tb/tb_redc_partition_scheduler.sv
// Randomized self-checking bench: traces of reads and controller runs are
// compared with a partition list derived directly from the pass parameters.
module tb_redc_partition_scheduler;

    localparam int unsigned WW = 8;
    localparam int unsigned RW = 2;
    localparam int unsigned SR = 128;
    localparam int unsigned AW = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [WW-1:0] n_kidx;
    logic [WW-1:0] n_steps;
    logic [RW-1:0] rsiz;
    logic [WW-1:0] part_step;
    logic [WW-1:0] part_kidx0;
    logic          busy;
    logic          done;
    logic          cfg_err;

    redc_partition_scheduler_if #(.WORD_WIDTH(WW), .RSIZ_WIDTH(RW), .STEP_RANGE(SR), .ADDR_WIDTH(AW)) bus ();

    redc_partition_scheduler #(.WORD_WIDTH(WW), .RSIZ_WIDTH(RW), .STEP_RANGE(SR), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .n_kidx     (n_kidx),
        .n_steps    (n_steps),
        .rsiz       (rsiz),
        .bus        (bus),
        .part_step  (part_step),
        .part_kidx0 (part_kidx0),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [WW*SR-1:0] mem_word(input logic [AW-1:0] a);
        mem_word = '0;
        for (int i = 0; i < int'(SR); i++) mem_word[i*WW +: WW] = (a[7:0] ^ 8'h5A) + 8'(i);
    endfunction

    always @(posedge clk) bus.mem_rd_data <= bus.mem_rd_en ? mem_word(bus.mem_rd_addr) : '0;

    // Observed trace
    int q_addr[$], q_kidx[$], q_col[$], q_run[$], q_rsiz[$], q_k0[$], q_step[$];
    int done_cnt, cfg_cnt, rd_cnt, run_len, first_rd, first_en;

    task automatic clear_mon();
        q_addr.delete(); q_kidx.delete(); q_col.delete(); q_run.delete();
        q_rsiz.delete(); q_k0.delete(); q_step.delete();
        done_cnt = 0; cfg_cnt = 0; rd_cnt = 0; run_len = 0; first_rd = -1; first_en = -1;
    endtask

    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            if (bus.mem_rd_en) begin
                q_addr.push_back(int'(bus.mem_rd_addr));
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (bus.rc_enable) begin
                if (run_len == 0) begin
                    q_k0.push_back(int'(part_kidx0));
                    q_step.push_back(int'(part_step));
                    q_rsiz.push_back(int'(bus.rc_rsiz));
                    if (first_en < 0) first_en = cyc;
                end
                run_len++;
                q_kidx.push_back(int'(bus.rc_kidx));
                q_col.push_back(int'(bus.rc_lifm_column[7:0]));
            end else if (run_len > 0) begin
                q_run.push_back(run_len);
                run_len = 0;
            end
            if (done) done_cnt++;
            if (cfg_err) cfg_cnt++;
        end
    end

    // Controller stand-in: pulses rc_valid some cycles after each column run ends.
    bit resp_en = 0;
    bit resp_rand = 0;
    int resp_lat = 5;
    bit resp_prev = 0;
    initial begin
        bus.rc_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && resp_prev && !bus.rc_enable) begin
                repeat (resp_rand ? int'($urandom_range(0, 6)) : resp_lat) @(negedge clk);
                bus.rc_valid = 1'b1;
                @(negedge clk);
                bus.rc_valid = 1'b0;
            end
            resp_prev = bus.rc_enable;
        end
    end

    // Reference: the list of partitions a full pass must produce.
    int exp_addr[$], exp_kidx[$], exp_psz[$], exp_k0[$], exp_step[$];

    task automatic build_model(input int nk, input int ns, input int rs);
        exp_addr.delete(); exp_kidx.delete(); exp_psz.delete(); exp_k0.delete(); exp_step.delete();
        for (int s = 0; s < ns; s++) begin
            for (int k0 = 0; k0 < nk; k0 += rs) begin
                int p;
                p = (nk - k0 < rs) ? nk - k0 : rs;
                exp_psz.push_back(p);
                exp_k0.push_back(k0);
                exp_step.push_back(s);
                for (int j = 0; j < p; j++) begin
                    exp_addr.push_back(s * nk + k0 + j);
                    exp_kidx.push_back(k0 + j);
                end
            end
        end
    endtask

    task automatic set_cfg(input int nk, input int ns, input int rs);
        n_kidx  = WW'(nk);
        n_steps = WW'(ns);
        rsiz    = RW'(rs);
    endtask

    task automatic run_pass(input int nk, input int ns, input int rs, output bit ok);
        ok = 0;
        clear_mon();
        build_model(nk, ns, rs);
        set_cfg(nk, ns, rs);
        resp_en = 1;
        @(negedge clk);
        start_cyc = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);
        checks++;
        if ({busy, done, cfg_err, bus.mem_rd_en, bus.rc_enable} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, done, cfg_err, bus.mem_rd_en, bus.rc_enable});
        end
        checks++;
        if (bus.mem_rd_addr !== '0 || bus.rc_rsiz !== '0 || bus.rc_kidx !== '0) begin
            errors++;
            $display("FAIL reset_bus: got addr %0d rsiz %0d kidx %0d expected 0 0 0", bus.mem_rd_addr, bus.rc_rsiz, bus.rc_kidx);
        end
        checks++;
        if (part_step !== '0 || part_kidx0 !== '0) begin
            errors++;
            $display("FAIL reset_part: got step %0d kidx0 %0d expected 0 0", part_step, part_kidx0);
        end
    endtask

    task automatic test_full_pass();
        bit ok;
        resp_rand = 0;
        resp_lat = 5;
        run_pass(9, 2, 3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_timeout: got no done expected done"); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_at_done: got %b expected 1", busy); end
        idle(1);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL full_after_done: got busy %b done %b expected 0 0", busy, done);
        end
        idle(4);
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", done_cnt); end
        checks++;
        if (first_rd != start_cyc + 1 || first_en != start_cyc + 2) begin
            errors++;
            $display("FAIL full_latency: got rd %0d en %0d expected %0d %0d", first_rd - start_cyc, first_en - start_cyc, 1, 2);
        end
        checks++;
        if (q_addr.size() != 18 || q_kidx.size() != 18 || q_col.size() != 18) begin
            errors++;
            $display("FAIL full_count: got %0d/%0d/%0d expected 18", q_addr.size(), q_kidx.size(), q_col.size());
        end else begin
            for (int i = 0; i < 18; i++) begin
                checks++;
                if (q_addr[i] != i || q_kidx[i] != i % 9 || q_col[i] != ((i & 255) ^ 'h5A)) begin
                    errors++;
                    $display("FAIL full_item[%0d]: got addr %0d kidx %0d col %0d expected %0d %0d %0d",
                             i, q_addr[i], q_kidx[i], q_col[i], i, i % 9, (i & 255) ^ 'h5A);
                end
            end
        end
        checks++;
        if (q_run.size() != 6 || q_run[0] != 3 || q_run[5] != 3) begin
            errors++;
            $display("FAIL full_runs: got %0d runs expected 6 runs of 3", q_run.size());
        end
        idle(8);
    endtask

    task automatic test_partial();
        bit ok;
        int want_psz[5] = '{2, 2, 2, 2, 1};
        int want_k0[5] = '{0, 2, 4, 6, 8};
        resp_rand = 1;
        run_pass(9, 1, 2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL partial_timeout: got no done expected done"); end
        idle(3);
        checks++;
        if (q_run.size() != 5 || q_rsiz.size() != 5 || q_k0.size() != 5) begin
            errors++;
            $display("FAIL partial_count: got %0d/%0d/%0d expected 5", q_run.size(), q_rsiz.size(), q_k0.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q_rsiz[i] != want_psz[i] || q_run[i] != want_psz[i] || q_k0[i] != want_k0[i] || q_step[i] != 0) begin
                    errors++;
                    $display("FAIL partial_part[%0d]: got rsiz %0d run %0d k0 %0d step %0d expected %0d %0d %0d 0",
                             i, q_rsiz[i], q_run[i], q_k0[i], q_step[i], want_psz[i], want_psz[i], want_k0[i]);
                end
            end
        end
        idle(8);
    endtask

    task automatic test_cfg_err();
        int cases[3][3] = '{'{9, 2, 1}, '{0, 2, 2}, '{9, 0, 3}};
        resp_en = 0;
        for (int c = 0; c < 3; c++) begin
            clear_mon();
            set_cfg(cases[c][0], cases[c][1], cases[c][2]);
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_pulse[%0d]: got cfg_err %b busy %b expected 1 0", c, cfg_err, busy);
            end
            idle(4);
            checks++;
            if (cfg_cnt != 1 || rd_cnt != 0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err_after[%0d]: got pulses %0d reads %0d busy %b expected 1 0 0", c, cfg_cnt, rd_cnt, busy);
            end
        end
        clear_mon();
        set_cfg(9, 1, 3);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        idle(3);
        checks++;
        if (busy !== 1'b0 || rd_cnt != 0 || cfg_cnt != 0) begin
            errors++;
            $display("FAIL abort_beats_start: got busy %b reads %0d cfg %0d expected 0 0 0", busy, rd_cnt, cfg_cnt);
        end
        idle(4);
    endtask

    task automatic test_spurious_valid();
        int i;
        clear_mon();
        resp_en = 0;
        set_cfg(4, 1, 2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.rc_valid = 1'b1;
        idle(2);
        checks++;
        if (bus.rc_enable !== 1'b1 || bus.mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL spurious_first_wait: got en %b rd %b expected 1 0", bus.rc_enable, bus.mem_rd_en);
        end
        @(negedge clk);
        bus.rc_valid = 1'b0;
        idle(4);
        checks++;
        if (busy !== 1'b1 || rd_cnt != 2 || bus.mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL spurious_ignored: got busy %b reads %0d rd %b expected 1 2 0", busy, rd_cnt, bus.mem_rd_en);
        end
        bus.rc_valid = 1'b1;
        @(negedge clk);
        bus.rc_valid = 1'b0;
        checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_rd_addr !== AW'(2)) begin
            errors++;
            $display("FAIL spurious_next_issue: got rd %b addr %0d expected 1 2", bus.mem_rd_en, bus.mem_rd_addr);
        end
        resp_rand = 0;
        resp_lat = 2;
        resp_en = 1;
        for (i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
        idle(2);
        checks++;
        if (done_cnt != 1 || q_addr.size() != 4 || q_addr[3] != 3) begin
            errors++;
            $display("FAIL spurious_finish: got done %0d reads %0d expected 1 4", done_cnt, q_addr.size());
        end
        idle(8);
    endtask

    task automatic test_abort();
        int falls = 0;
        bit prev = 0;
        bit ok;
        clear_mon();
        resp_rand = 0;
        resp_lat = 4;
        resp_en = 1;
        set_cfg(9, 2, 3);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 300 && falls < 3; i++) begin
            @(negedge clk);
            if (prev && !bus.rc_enable) falls++;
            prev = bus.rc_enable;
        end
        checks++;
        if (falls != 3) begin errors++; $display("FAIL abort_reach_wait: got %0d partitions expected 3", falls); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.rc_enable !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy %b rd %b en %b expected 0 0 0", busy, bus.mem_rd_en, bus.rc_enable);
        end
        idle(10);
        checks++;
        if (done_cnt != 0 || busy !== 1'b0 || rd_cnt != 9) begin
            errors++;
            $display("FAIL abort_quiet: got done %0d busy %b reads %0d expected 0 0 9", done_cnt, busy, rd_cnt);
        end
        run_pass(9, 1, 3, ok);
        idle(2);
        checks++;
        if (!ok || q_addr.size() != 9 || q_addr[0] != 0 || q_addr[8] != 8 || done_cnt != 1) begin
            errors++;
            $display("FAIL abort_restart: got ok %0d reads %0d done %0d expected 1 9 1", ok, q_addr.size(), done_cnt);
        end
        idle(8);
    endtask

    task automatic test_async_reset();
        clear_mon();
        resp_rand = 0;
        resp_lat = 3;
        resp_en = 1;
        set_cfg(9, 1, 3);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.rc_enable !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got rd %b en %b expected 1 1", bus.mem_rd_en, bus.rc_enable);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_rd_en !== 1'b0 || bus.rc_enable !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: got rd %b en %b busy %b expected 0 0 0", bus.mem_rd_en, bus.rc_enable, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(8);
        checks++;
        if (busy !== 1'b0 || rd_cnt != 2 || done_cnt != 0) begin
            errors++;
            $display("FAIL areset_after: got busy %b reads %0d done %0d expected 0 2 0", busy, rd_cnt, done_cnt);
        end
        idle(4);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int nk, ns, rs, bad;
        resp_rand = 1;
        for (int t = 0; t < 6; t++) begin
            nk = int'($urandom_range(1, 12));
            ns = int'($urandom_range(1, 3));
            rs = int'($urandom_range(2, 3));
            run_pass(nk, ns, rs, ok);
            idle(2);
            checks++;
            if (!ok || done_cnt != 1) begin
                errors++;
                $display("FAIL b2b_done[%0d]: got ok %0d done %0d expected 1 1 (nk %0d ns %0d rs %0d)", t, ok, done_cnt, nk, ns, rs);
            end
            bad = 0;
            if (q_addr.size() != exp_addr.size() || q_run.size() != exp_psz.size()) bad = -1;
            else begin
                foreach (exp_addr[i]) if (q_addr[i] != exp_addr[i] || q_kidx[i] != exp_kidx[i]) bad++;
                foreach (exp_psz[i])
                    if (q_run[i] != exp_psz[i] || q_rsiz[i] != exp_psz[i] || q_k0[i] != exp_k0[i] || q_step[i] != exp_step[i]) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL b2b_trace[%0d]: got reads %0d parts %0d bad %0d expected reads %0d parts %0d bad 0",
                         t, q_addr.size(), q_run.size(), bad, exp_addr.size(), exp_psz.size());
            end
            idle(8);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        n_kidx = '0;
        n_steps = '0;
        rsiz = '0;
        test_reset();
        test_full_pass();
        test_partial();
        test_cfg_err();
        test_spurious_valid();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
